wave_instr_buffer: RTL

Per-wavefront instruction buffer that sits directly upstream of the decode stage. It receives fetched instruction dwords tagged by wavefront ID and holds them in one small FIFO per wavefront. It selects one ready wavefront at a time, round-robin, and drives the `wave_*` instruction bus into decode. It serves decode's second-half request for 64-bit instructions and instructions with a literal, and it flushes a wavefront's queue on redirect.

---
 rtl/wave_instr_buffer.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wave_instr_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wave_instr_buffer
// Purpose  : Per-wavefront instruction dword FIFOs feeding decode. Selects one
//            ready wavefront round-robin and issues from it, serves decode's
//            second-half request, and flushes a wavefront on redirect.
// Revision : 1.0 - initial release
// ============================================================================
module wave_instr_buffer #(
  parameter int NUM_WF = 40,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch_valid,
  input  logic [5:0]        dispatch_wfid,
  input  logic [9:0]        dispatch_vgpr_base,
  input  logic [8:0]        dispatch_sgpr_base,
  input  logic [15:0]       dispatch_lds_base,
  input  logic              fetch_valid,
  input  logic [5:0]        fetch_wfid,
  input  logic [31:0]       fetch_pc,
  input  logic [31:0]       fetch_instr,
  input  logic [NUM_WF-1:0] sched_ready,
  input  logic              flush_valid,
  input  logic [5:0]        flush_wfid,
  input  logic              wave_ins_half_rqd,
  input  logic [5:0]        wave_ins_half_wfid,
  output logic              wave_instr_valid,
  output logic [5:0]        wave_wfid,
  output logic [31:0]       wave_instr_pc,
  output logic [31:0]       wave_instr,
  output logic [9:0]        wave_vgpr_base,
  output logic [8:0]        wave_sgpr_base,
  output logic [15:0]       wave_lds_base,
  output logic [NUM_WF-1:0] fetch_space,
  output logic              overflow_err
);

  localparam int              c_pw        = $clog2(DEPTH);
  localparam int              c_cw        = c_pw + 1;
  localparam logic [c_cw-1:0] c_full      = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_space_max = c_cw'(DEPTH - 2);
  localparam logic [5:0]      c_last_wf   = 6'(NUM_WF - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HALF = 2'd1,
    ST_HALF      = 2'd2
  } state_t;

  // Control state
  state_t     state_q, state_d;
  logic [5:0] rr_ptr_q, rr_ptr_d;
  logic [5:0] half_wf_q, half_wf_d;
  logic [5:0] last_wf_q, last_wf_d;

  // Per-wavefront storage
  logic [c_pw-1:0] rd_ptr_q [NUM_WF];
  logic [c_pw-1:0] wr_ptr_q [NUM_WF];
  logic [c_cw-1:0] cnt_q    [NUM_WF];
  logic [31:0]     mem_pc_q  [NUM_WF][DEPTH];
  logic [31:0]     mem_ins_q [NUM_WF][DEPTH];
  logic [9:0]      vgpr_q [NUM_WF];
  logic [8:0]      sgpr_q [NUM_WF];
  logic [15:0]     lds_q  [NUM_WF];

  // Registered output bus
  logic        out_valid_q;
  logic [5:0]  out_wfid_q;
  logic [31:0] out_pc_q, out_ins_q;
  logic [9:0]  out_vgpr_q;
  logic [8:0]  out_sgpr_q;
  logic [15:0] out_lds_q;
  logic        overflow_q;

  // Combinational helpers
  logic [NUM_WF-1:0] w_nonempty, w_cand, w_flush, w_wr_en, w_rd_en;
  logic              w_half_ne;
  logic              w_found;
  logic [5:0]        w_grant;
  logic              w_pop_en;
  logic [5:0]        w_pop_wf;
  logic              w_ovf;
  logic [31:0]       w_head_pc, w_head_ins;
  logic [9:0]        w_head_vgpr;
  logic [8:0]        w_head_sgpr;
  logic [15:0]       w_head_lds;

  // Per-wavefront status flags and the half-request target's occupancy
  always_comb begin
    w_half_ne = 1'b0;
    for (int i = 0; i < NUM_WF; i++) begin
      w_nonempty[i] = (cnt_q[i] != '0);
      w_cand[i]     = w_nonempty[i] & sched_ready[i];
      w_flush[i]    = flush_valid && (flush_wfid == 6'(i));
      fetch_space[i] = (cnt_q[i] <= c_space_max);
      if (half_wf_q == 6'(i)) w_half_ne = w_nonempty[i];
    end
  end

  // Round-robin: first candidate at or after rr_ptr, else lowest candidate (wrap)
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      if (!w_found && w_cand[i] && (6'(i) >= rr_ptr_q)) begin
        w_found = 1'b1;
        w_grant = 6'(i);
      end
    end
    for (int i = 0; i < NUM_WF; i++) begin
      if (!w_found && w_cand[i]) begin
        w_found = 1'b1;
        w_grant = 6'(i);
      end
    end
  end

  // Issue state machine: next state and pop selection
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    half_wf_d = half_wf_q;
    last_wf_d = last_wf_q;
    w_pop_en  = 1'b0;
    w_pop_wf  = w_grant;
    case (state_q)
      ST_IDLE: begin
        // A flush of the granted wavefront suppresses the pop; retry next cycle
        if (w_found && !w_flush[w_grant]) begin
          w_pop_en  = 1'b1;
          w_pop_wf  = w_grant;
          last_wf_d = w_grant;
          rr_ptr_d  = (w_grant == c_last_wf) ? 6'd0 : w_grant + 6'd1;
          state_d   = ST_WAIT_HALF;
        end
      end
      ST_WAIT_HALF: begin
        if (flush_valid && (flush_wfid == last_wf_q)) begin
          state_d = ST_IDLE;
        end else if (wave_ins_half_rqd) begin
          half_wf_d = wave_ins_half_wfid;
          state_d   = ST_HALF;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALF: begin
        // Locked to half_wf until its next dword arrives or it is flushed
        if (flush_valid && (flush_wfid == half_wf_q)) begin
          state_d = ST_IDLE;
        end else if (w_half_ne) begin
          w_pop_en  = 1'b1;
          w_pop_wf  = half_wf_q;
          last_wf_d = half_wf_q;
          state_d   = ST_WAIT_HALF;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write/read enables per FIFO; a write to a full FIFO is legal only if it pops too
  always_comb begin
    w_ovf = 1'b0;
    for (int i = 0; i < NUM_WF; i++) begin
      w_rd_en[i] = w_pop_en && (w_pop_wf == 6'(i));
      w_wr_en[i] = 1'b0;
      if (fetch_valid && (fetch_wfid == 6'(i)) && !w_flush[i]) begin
        if ((cnt_q[i] != c_full) || w_rd_en[i]) w_wr_en[i] = 1'b1;
        else                                    w_ovf      = 1'b1;
      end
    end
  end

  // Head entry and bases of the wavefront being popped
  always_comb begin
    w_head_pc   = '0;
    w_head_ins  = '0;
    w_head_vgpr = '0;
    w_head_sgpr = '0;
    w_head_lds  = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      if (w_pop_wf == 6'(i)) begin
        w_head_pc   = mem_pc_q[i][rd_ptr_q[i]];
        w_head_ins  = mem_ins_q[i][rd_ptr_q[i]];
        w_head_vgpr = vgpr_q[i];
        w_head_sgpr = sgpr_q[i];
        w_head_lds  = lds_q[i];
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      half_wf_q <= '0;
      last_wf_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      half_wf_q <= half_wf_d;
      last_wf_q <= last_wf_d;
    end
  end

  // FIFO pointers, counts and base registers; flush zeroes pointers but keeps bases
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WF; i++) begin
      if (rst) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        vgpr_q[i]   <= '0;
        sgpr_q[i]   <= '0;
        lds_q[i]    <= '0;
      end else begin
        if (w_flush[i]) begin
          rd_ptr_q[i] <= '0;
          wr_ptr_q[i] <= '0;
          cnt_q[i]    <= '0;
        end else begin
          if (w_wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
          if (w_rd_en[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
          case ({w_wr_en[i], w_rd_en[i]})
            2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
            2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
            default: cnt_q[i] <= cnt_q[i];
          endcase
        end
        if (dispatch_valid && (dispatch_wfid == 6'(i))) begin
          vgpr_q[i] <= dispatch_vgpr_base;
          sgpr_q[i] <= dispatch_sgpr_base;
          lds_q[i]  <= dispatch_lds_base;
        end
      end
    end
  end

  // FIFO data arrays; contents need no reset since counts gate every read
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WF; i++) begin
      if (w_wr_en[i]) begin
        mem_pc_q[i][wr_ptr_q[i]]  <= fetch_pc;
        mem_ins_q[i][wr_ptr_q[i]] <= fetch_instr;
      end
    end
  end

  // Output bus: payload held while idle, valid pulses for one cycle per pop
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_wfid_q  <= '0;
      out_pc_q    <= '0;
      out_ins_q   <= '0;
      out_vgpr_q  <= '0;
      out_sgpr_q  <= '0;
      out_lds_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= w_pop_en;
      if (w_pop_en) begin
        out_wfid_q <= w_pop_wf;
        out_pc_q   <= w_head_pc;
        out_ins_q  <= w_head_ins;
        out_vgpr_q <= w_head_vgpr;
        out_sgpr_q <= w_head_sgpr;
        out_lds_q  <= w_head_lds;
      end
      if (w_ovf) overflow_q <= 1'b1;
    end
  end

  assign wave_instr_valid = out_valid_q;
  assign wave_wfid        = out_wfid_q;
  assign wave_instr_pc    = out_pc_q;
  assign wave_instr       = out_ins_q;
  assign wave_vgpr_base   = out_vgpr_q;
  assign wave_sgpr_base   = out_sgpr_q;
  assign wave_lds_base    = out_lds_q;
  assign overflow_err     = overflow_q;

endmodule
`default_nettype wire
